// File: rtl/coriolis_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_div_pkg
// Description : Shared constants for the Coriolis divider-sharing arbiter.
//               Holds the requester-id tag width, the FloPoCo "normal number"
//               exception code and the default divider pipeline latency, plus
//               the round-robin pointer helper.
// Revision    : 1.0 - initial release
// ============================================================================
package coriolis_div_pkg;

    // Width of the requester id carried alongside each in-flight divide.
    localparam int c_tag_idw = 2;

    // FloPoCo exception field value for an ordinary (non-zero, finite) number.
    localparam logic [1:0] c_fp_exc_normal = 2'b01;

    // Latency of the external divider pipeline, in advancing cycles.
    localparam int c_default_lat = 13;

    // Round-robin successor of requester id among nreq requesters.
    function automatic logic [c_tag_idw-1:0] rr_next(
        input logic [c_tag_idw-1:0] id,
        input int                   nreq
    );
        if (int'(id) == nreq - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage : coriolis_div_pkg
`default_nettype wire

// File: rtl/coriolis_div_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_div_tag_pipe
// Description : LAT-deep stallable {valid, id} shift register that travels in
//               lock-step with the external divider so the arbiter knows which
//               requester owns the result currently at the divider output.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               adv             - shift enable (divider advancing)
//               in_valid, in_id - tag entering stage 0
//               exit_valid/id   - tag in the last stage (aligned with div_r)
// Revision    : 1.0 - initial release
// ============================================================================
module coriolis_div_tag_pipe
    import coriolis_div_pkg::*;
#(
    parameter int LAT = c_default_lat,
    parameter int IDW = c_tag_idw
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv,
    input  logic           in_valid,
    input  logic [IDW-1:0] in_id,
    output logic           exit_valid,
    output logic [IDW-1:0] exit_id
);

    logic [LAT-1:0] r_valid;
    logic [IDW-1:0] r_id [LAT];

    // Valid bits are reset so in-flight work is discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (adv) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Ids are don't-care when their valid is low, so they need no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            r_id[0] <= in_id;
            for (int k = 1; k < LAT; k++) begin
                r_id[k] <= r_id[k-1];
            end
        end
    end

    assign exit_valid = r_valid[LAT-1];
    assign exit_id    = r_id[LAT-1];

endmodule : coriolis_div_tag_pipe
`default_nettype wire

// File: rtl/coriolis_div_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_div_share_arb
// Description : Shares one pipelined FloPoCo divider between NREQ requester
//               streams. Round-robin issue, a tag pipeline tracking ownership,
//               and one result slot per requester. The divider is stalled only
//               when a valid result exits towards a full, non-draining slot.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               req_valid/ready/x/y   - per-requester operand handshake
//               rsp_valid/ready/data  - per-requester result handshake
//               div_x, div_y, div_r   - external divider operands / result
//               div_stall             - freezes the external divider
//               perf_issue_cnt,
//               perf_stall_cnt        - only with CORIOLIS_DIV_ARB_PERF_EN
// Options     : CORIOLIS_DIV_ARB_PERF_EN adds issue / stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module coriolis_div_share_arb
    import coriolis_div_pkg::*;
#(
    parameter int STREAMW = 34,
    parameter int NREQ    = 2,
    parameter int LAT     = c_default_lat
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*STREAMW-1:0] req_x,
    input  logic [NREQ*STREAMW-1:0] req_y,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [NREQ*STREAMW-1:0] rsp_data,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [STREAMW-1:0]      div_x,
    output logic [STREAMW-1:0]      div_y,
    output logic                    div_stall,
`ifdef CORIOLIS_DIV_ARB_PERF_EN
    output logic [31:0]             perf_issue_cnt,
    output logic [31:0]             perf_stall_cnt,
`endif
    input  logic [STREAMW-1:0]      div_r
);

    logic [c_tag_idw-1:0]    r_ptr;
    logic [NREQ-1:0]         r_rsp_valid;
    logic [NREQ*STREAMW-1:0] r_rsp_data;

    logic                    w_exit_valid;
    logic [c_tag_idw-1:0]    w_exit_id;
    logic                    w_blocked;
    logic                    w_adv;
    logic                    w_gnt_any;
    logic [c_tag_idw-1:0]    w_gnt_id;
    logic                    w_gnt;

    // Only an exiting valid result aimed at a full slot that is not being
    // drained this cycle can hold the pipeline.
    always_comb begin
        w_blocked = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_exit_valid && (w_exit_id == c_tag_idw'(i)) &&
                r_rsp_valid[i] && !rsp_ready[i]) begin
                w_blocked = 1'b1;
            end
        end
    end

    assign w_adv     = ~w_blocked;
    assign div_stall = ~rst & w_blocked;

    // First valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_gnt_any && req_valid[i] &&
                    (((int'(r_ptr) + k) % NREQ) == i)) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = c_tag_idw'(i);
                end
            end
        end
    end

    assign w_gnt = ~rst & w_adv & w_gnt_any;

    always_comb begin
        req_ready = '0;
        div_x     = '0;
        div_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt && (w_gnt_id == c_tag_idw'(i))) begin
                req_ready[i] = 1'b1;
                div_x        = req_x[i*STREAMW +: STREAMW];
                div_y        = req_y[i*STREAMW +: STREAMW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_gnt) begin
            r_ptr <= rr_next(w_gnt_id, NREQ);
        end
    end

    coriolis_div_tag_pipe #(
        .LAT (LAT),
        .IDW (c_tag_idw)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .adv        (w_adv),
        .in_valid   (w_gnt),
        .in_id      (w_gnt_id),
        .exit_valid (w_exit_valid),
        .exit_id    (w_exit_id)
    );

    // A reload takes priority over a drain, so a slot drained and refilled
    // on the same edge stays valid with the new quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_adv && w_exit_valid && (w_exit_id == c_tag_idw'(i))) begin
                    r_rsp_valid[i]                  <= 1'b1;
                    r_rsp_data[i*STREAMW +: STREAMW] <= div_r;
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

`ifdef CORIOLIS_DIV_ARB_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_gnt) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (!w_adv) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule : coriolis_div_share_arb
`default_nettype wire

// File: tb/tb_coriolis_div_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_coriolis_div_share_arb
// Description : Self-checking bench for coriolis_div_share_arb. A stall-aware
//               behavioural divider (LAT registers) drives div_r; a reference
//               model (countdown queue of in-flight ops, per-requester slot
//               flags, round-robin pointer) predicts handshakes, and a
//               scoreboard of expected quotients is checked on every result
//               consumed. Optional perf counters follow
//               CORIOLIS_DIV_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coriolis_div_share_arb;

    localparam int SW   = 34;
    localparam int NREQ = 2;
    localparam int LAT  = 13;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SW-1:0]   req_x;
    logic [NREQ*SW-1:0]   req_y;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*SW-1:0]   rsp_data;
    logic [NREQ-1:0]      rsp_ready;
    logic [SW-1:0]        div_x;
    logic [SW-1:0]        div_y;
    logic                 div_stall;
    logic [SW-1:0]        div_r;
`ifdef CORIOLIS_DIV_ARB_PERF_EN
    logic [31:0]          perf_issue_cnt;
    logic [31:0]          perf_stall_cnt;
`endif

    coriolis_div_share_arb #(
        .STREAMW (SW),
        .NREQ    (NREQ),
        .LAT     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_stall (div_stall),
`ifdef CORIOLIS_DIV_ARB_PERF_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .div_r     (div_r)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checks
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ FP divide model
    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        d = {s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = int'(d[62:52]) - 896;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [SW-1:0] fp_div(input logic [SW-1:0] x, input logic [SW-1:0] y);
        if (y[30:0] == 31'd0) return {2'b01, 32'd0};
        return {2'b01, r2sp(sp2r(x[31:0]) / sp2r(y[31:0]))};
    endfunction

    function automatic logic [SW-1:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        e = 8'($urandom_range(140, 110));
        m = 23'($urandom);
        return {2'b01, 1'($urandom), e, m};
    endfunction

    // Stall-aware external divider: LAT registers advancing when not stalled.
    logic [SW-1:0] dpipe [LAT];
    always @(posedge clk) begin
        if (!div_stall) begin
            dpipe[0] <= fp_div(div_x, div_y);
            for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
        end
    end
    assign div_r = dpipe[LAT-1];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ------------------------------------------------------ reference model
    int            fq_id[$];          // in-flight ops, issue order
    int            fq_rem[$];         // advancing edges left until at exit
    logic [SW-1:0] sb[NREQ][$];       // expected quotients per requester
    bit            m_full[NREQ];
    int            m_ptr = 0;
    int            res_cnt[NREQ];
    int            gnt_log[$];
    int            n_issue_total = 0;
    int            t_acc0 = 0;
    bit            saw_ready1 = 0;
    logic [NREQ-1:0] acc_last = '0;
    int            m_perf_issue = 0;
    int            m_perf_stall = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_full;
        bit              any, m_exit, m_adv;
        int              g, hid, idx;
        logic [SW-1:0]   exp_q;

        m_exit = (fq_id.size() > 0) && (fq_rem[0] == 0);
        hid    = m_exit ? fq_id[0] : 0;
        m_adv  = !(m_exit && m_full[hid] && !rsp_ready[hid]);
        any    = 0;
        g      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (!any && req_valid[idx]) begin
                any = 1;
                g   = idx;
            end
        end
        e_ready = (!rst && m_adv && any) ? (NREQ'(1) << g) : '0;
        for (int i = 0; i < NREQ; i++) e_full[i] = m_full[i];

        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("div_stall", 64'(div_stall), 64'(!rst && !m_adv));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_full));
        if (req_ready[1]) saw_ready1 = 1;

        if (rst) begin
            fq_id.delete();
            fq_rem.delete();
            for (int i = 0; i < NREQ; i++) begin
                sb[i].delete();
                m_full[i] = 0;
            end
            m_ptr        = 0;
            m_perf_issue = 0;
            m_perf_stall = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_full[i] && rsp_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        chk("rsp_unexpected", 64'(i), 64'hFFFF);
                    end else begin
                        exp_q = sb[i].pop_front();
                        chk($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*SW +: SW]), 64'(exp_q));
                    end
                    res_cnt[i]++;
                    m_full[i] = 0;
                end
            end
            if (m_adv) begin
                if (m_exit) begin
                    m_full[hid] = 1;
                    void'(fq_id.pop_front());
                    void'(fq_rem.pop_front());
                end
                foreach (fq_rem[k]) fq_rem[k]--;
                if (any) begin
                    fq_id.push_back(g);
                    fq_rem.push_back(LAT - 1);
                    sb[g].push_back(fp_div(req_x[g*SW +: SW], req_y[g*SW +: SW]));
                    gnt_log.push_back(g);
                    m_ptr = (g + 1) % NREQ;
                    n_issue_total++;
                    m_perf_issue++;
                    if (g == 0) t_acc0 = edge_cnt + 1;
                end
            end else begin
                m_perf_stall++;
            end
        end
        acc_last = req_valid & req_ready;
    end

    // ----------------------------------------------------------- stimulus
    int            to_send[NREQ];
    int            p_valid = 100;
    int            rdy_force[NREQ];    // 0 low, 1 high, 2 random
    bit            use_fixed0 = 0;
    logic [SW-1:0] fixed_x, fixed_y;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                req_valid[i] = 1'b0;
            end else if (!req_valid[i] || acc_last[i]) begin
                if (to_send[i] > 0 && int'($urandom_range(99, 0)) < p_valid) begin
                    req_valid[i] = 1'b1;
                    if (i == 0 && use_fixed0) begin
                        req_x[i*SW +: SW] = fixed_x;
                        req_y[i*SW +: SW] = fixed_y;
                        use_fixed0 = 0;
                    end else begin
                        req_x[i*SW +: SW] = rand_fp();
                        req_y[i*SW +: SW] = rand_fp();
                    end
                    to_send[i]--;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            if (rdy_force[i] == 2) rsp_ready[i] = ($urandom_range(99, 0) < 70);
            else                   rsp_ready[i] = (rdy_force[i] == 1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic set_rdy(input int v);
        for (int i = 0; i < NREQ; i++) rdy_force[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base[NREQ];
        int t_rsp, cnt, viol;
        bit prev, refill;

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) to_send[i] = 0;
        set_rdy(1);
        repeat (3) cycle();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_div_stall", 64'(div_stall), 64'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // Single op: 1000.0 / 10.0 from requester 0. The accepting edge counts
        // as the first of the LAT+1 edges before rsp_valid is seen.
        fixed_x    = {2'b01, 32'h447A0000};
        fixed_y    = {2'b01, 32'h41200000};
        use_fixed0 = 1;
        to_send[0] = 1;
        saw_ready1 = 0;
        t_rsp      = -1;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (rsp_valid[0]) begin
                t_rsp = edge_cnt;
                break;
            end
        end
        chk("single_latency", 64'(t_rsp - t_acc0 + 1), 64'(LAT + 1));
        chk("single_data", 64'(rsp_data[SW-1:0]), 64'({2'b01, 32'h42C80000}));
        repeat (3) cycle();
        chk("single_ready1_low", 64'(saw_ready1), 64'd0);

        // Both requesters continuously valid: strict alternation, 4 each.
        gnt_log.delete();
        for (int i = 0; i < NREQ; i++) base[i] = res_cnt[i];
        to_send[0] = 4;
        to_send[1] = 4;
        repeat (30) cycle();
        viol = 0;
        for (int k = 1; k < gnt_log.size(); k++) if (gnt_log[k] == gnt_log[k-1]) viol++;
        chk("alt_grant_count", 64'(gnt_log.size()), 64'd8);
        chk("alt_violations", 64'(viol), 64'd0);
        chk("alt_results_0", 64'(res_cnt[0] - base[0]), 64'd4);
        chk("alt_results_1", 64'(res_cnt[1] - base[1]), 64'd4);

        // Backpressure on requester 1 with a second result exiting.
        rdy_force[1] = 0;
        to_send[1]   = 2;
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (div_stall) break;
        end
        chk("stall_reached", 64'(div_stall), 64'd1);
        to_send[0] = 3;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_hold", 64'(div_stall), 64'd1);
        end
        rdy_force[1] = 1;
        repeat (30) cycle();
        chk("stall_released", 64'(div_stall), 64'd0);

        // Back-to-back results into slot 0 with the consumer always ready.
        to_send[0] = 2;
        cnt    = 0;
        prev   = 0;
        refill = 0;
        for (int n = 0; n < 30; n++) begin
            cycle();
            if (rsp_valid[0]) begin
                cnt++;
                if (prev) refill = 1;
            end
            prev = rsp_valid[0];
        end
        chk("refill_count", 64'(cnt), 64'd2);
        chk("refill_seen", 64'(refill), 64'd1);

        // Reset with five operations in flight.
        base[0]    = n_issue_total;
        to_send[0] = 3;
        to_send[1] = 3;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (n_issue_total - base[0] >= 5) break;
        end
        chk("inflight_before_rst", 64'(n_issue_total - base[0]), 64'd5);
        to_send[0] = 0;
        to_send[1] = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (rsp_valid != '0) cnt++;
        end
        chk("post_rst_rsp_valid", 64'(cnt), 64'd0);
        to_send[0] = 1;
        to_send[1] = 1;
        cycle();
        chk("post_rst_ptr", 64'(req_ready), 64'd1);
        repeat (25) cycle();

        // Randomised traffic with random consumers.
        p_valid = 60;
        set_rdy(2);
        to_send[0] = 1000;
        to_send[1] = 1000;
        repeat (400) cycle();
        to_send[0] = 0;
        to_send[1] = 0;
        set_rdy(1);
        repeat (40) cycle();
        chk("drain_sb0", 64'(sb[0].size()), 64'd0);
        chk("drain_sb1", 64'(sb[1].size()), 64'd0);
        chk("drain_inflight", 64'(fq_id.size()), 64'd0);
`ifdef CORIOLIS_DIV_ARB_PERF_EN
        chk("perf_issue_cnt", 64'(perf_issue_cnt), 64'(m_perf_issue));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_perf_stall));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_coriolis_div_share_arb
`default_nettype wire
